div_issue_hilo: RTL and testbench

- Execute-stage front end for the 32-cycle iterative divider.
- Accepts DIV/DIVU/MTHI/MTLO from the EX stage and latches the operands.
- Drives the divider's start, signed-mode and operand inputs, and stalls EX while a divide runs.
- On the divider's complete pulse, writes quotient to LO and remainder to HI; HI/LO are read combinationally by MFHI/MFLO.

---
 rtl/div_issue_hilo_pkg.sv | 38 +++
 rtl/div_issue_hilo_hilo_regs.sv | 53 +++++
 rtl/div_issue_hilo.sv | 122 ++++++++++++
 tb/tb_div_issue_hilo.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_hilo_pkg.sv
// Shared CPU definitions for the divide issue stage: datapath width, issue FSM
// states and the multiply/divide unit decode bit layout used by the decoder.
package div_issue_hilo_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

    // Bit positions of the HI/LO-unit decode vector, shared with the decoder
    localparam int OP_MTLO_BIT = 0;
    localparam int OP_MTHI_BIT = 1;
    localparam int OP_DIVU_BIT = 2;
    localparam int OP_DIV_BIT  = 3;
    localparam int OP_BITS     = 4;

    typedef logic [OP_BITS-1:0] mdu_op_t;

    function automatic mdu_op_t pack_mdu_op(input logic is_div,
                                            input logic is_divu,
                                            input logic is_mthi,
                                            input logic is_mtlo);
        mdu_op_t op;
        op              = '0;
        op[OP_DIV_BIT]  = is_div;
        op[OP_DIVU_BIT] = is_divu;
        op[OP_MTHI_BIT] = is_mthi;
        op[OP_MTLO_BIT] = is_mtlo;
        return op;
    endfunction

    function automatic logic op_is_divide(input mdu_op_t op);
        return op[OP_DIV_BIT] | op[OP_DIVU_BIT];
    endfunction

endpackage

// File: rtl/div_issue_hilo_hilo_regs.sv
// HI/LO architectural registers with a divide-writeback port and an MTHI/MTLO port.
module hilo_regs
    import div_issue_hilo_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wb_we_i,
    input  logic [WIDTH-1:0] wb_hi_i,
    input  logic [WIDTH-1:0] wb_lo_i,
    input  logic             mt_hi_we_i,
    input  logic             mt_lo_we_i,
    input  logic [WIDTH-1:0] mt_data_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Writeback only happens while a divide is busy and MT* only while idle,
    // so the two ports never collide; writeback is given priority regardless.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb_we_i) begin
            hi_d = wb_hi_i;
            lo_d = wb_lo_i;
        end else begin
            if (mt_hi_we_i) begin
                hi_d = mt_data_i;
            end
            if (mt_lo_we_i) begin
                lo_d = mt_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/div_issue_hilo.sv
// Execute-stage front end of the iterative divider: issues DIV/DIVU, stalls EX
// while the divide runs, and owns the HI/LO registers (also written by MTHI/MTLO).
module div_issue_hilo
    import div_issue_hilo_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_valid,
    input  logic             ex_div,
    input  logic             ex_divu,
    input  logic             ex_mthi,
    input  logic             ex_mtlo,
    input  logic             ex_flush,
    input  logic [WIDTH-1:0] ex_rs,
    input  logic [WIDTH-1:0] ex_rt,
    output logic             ex_stall,
    output logic             div_start,
    output logic             div_signed,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic [WIDTH-1:0] div_s,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_complete,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_e       state_q;
    logic             start_q;
    logic             signed_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    mdu_op_t op;
    logic    ex_live;
    logic    busy;
    logic    issue;
    logic    wb_we;
    logic    mt_hi_we;
    logic    mt_lo_we;

    always_comb begin
        op       = pack_mdu_op(ex_div, ex_divu, ex_mthi, ex_mtlo);
        ex_live  = ex_valid & ~ex_flush;
        busy     = (state_q == BUSY);
        issue    = ex_live & op_is_divide(op);
        // A flush on the complete cycle kills the writeback
        wb_we    = busy & div_complete & ~ex_flush;
        mt_hi_we = ~busy & ex_live & ~op_is_divide(op) & op[OP_MTHI_BIT];
        mt_lo_we = ~busy & ex_live & ~op_is_divide(op) & op[OP_MTLO_BIT];
    end

    // The divide leaves EX on the writeback edge, so stall drops on the complete cycle
    assign ex_stall = resetn & ((~busy & issue) | (busy & ~div_complete));

    // Issue FSM; dropping start on every return to IDLE lets the divider's counter clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        x_q      <= ex_rs;
                        y_q      <= ex_rt;
                        signed_q <= ex_div;
                        start_q  <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (ex_flush || div_complete) begin
                        start_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_start  = start_q;
    assign div_signed = signed_q;
    assign div_x      = x_q;
    assign div_y      = y_q;

    hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .wb_we_i   (wb_we),
        .wb_hi_i   (div_r),
        .wb_lo_i   (div_s),
        .mt_hi_we_i(mt_hi_we),
        .mt_lo_we_i(mt_lo_we),
        .mt_data_i (ex_rs),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    a_busy_drives_start : assert property (
        @(posedge clk) disable iff (!resetn) busy |-> div_start);

    a_operands_hold : assert property (
        @(posedge clk) disable iff (!resetn)
        (busy && !ex_flush && !div_complete) |=>
        (div_start && div_x == $past(div_x) && div_y == $past(div_y)));

    a_start_drops_after_wb : assert property (
        @(posedge clk) disable iff (!resetn) wb_we |=> !div_start);

endmodule

// File: tb/tb_div_issue_hilo.sv
// Bench for div_issue_hilo: a stand-in 32-cycle divider, a transaction-level
// model of HI/LO and stall timing, and directed divide/MT/flush/reset vectors.
module tb_div_issue_hilo;
    import div_issue_hilo_pkg::*;

    localparam int W      = DIV_WIDTH;
    localparam int WB_AGE = 33;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         exValid = 1'b0, exDiv = 1'b0, exDivu = 1'b0;
    logic         exMthi = 1'b0, exMtlo = 1'b0, exFlush = 1'b0;
    logic [W-1:0] exRs = '0, exRt = '0;
    logic         exStall, divStart, divSigned, divComplete;
    logic [W-1:0] divX, divY, divS, divR, hi, lo;

    logic         injC = 1'b0;
    logic [W-1:0] injS = '0, injR = '0;

    int testsRun  = 0;
    int failures  = 0;
    bit cmpEnable = 1'b0;

    div_issue_hilo dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_valid    (exValid),
        .ex_div      (exDiv),
        .ex_divu     (exDivu),
        .ex_mthi     (exMthi),
        .ex_mtlo     (exMtlo),
        .ex_flush    (exFlush),
        .ex_rs       (exRs),
        .ex_rt       (exRt),
        .ex_stall    (exStall),
        .div_start   (divStart),
        .div_signed  (divSigned),
        .div_x       (divX),
        .div_y       (divY),
        .div_s       (divS),
        .div_r       (divR),
        .div_complete(divComplete),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Returns {remainder, quotient}; divide by zero yields all-ones and the dividend
    function automatic logic [2*W-1:0] refDivide(input logic sgn, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [W-1:0] q, r;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    // Stand-in divider: counter clears whenever div is low, operands latched at count 0->1
    int           divCnt    = 0;
    logic [W-1:0] latX      = '0, latY = '0;
    logic         latSigned = 1'b0;
    logic [2*W-1:0] stubRes;

    always @(posedge clk) begin
        if (!divStart) begin
            divCnt <= 0;
        end else begin
            divCnt <= divCnt + 1;
            if (divCnt == 0) begin
                latX      <= divX;
                latY      <= divY;
                latSigned <= divSigned;
            end
        end
    end

    assign stubRes     = refDivide(latSigned, latX, latY);
    assign divComplete = (divCnt == WB_AGE) | injC;
    assign divS        = injC ? injS : stubRes[W-1:0];
    assign divR        = injC ? injR : stubRes[2*W-1:W];

    // Model: a divide accepted at E0 commits its precomputed result at E34 unless flushed
    logic         mBusy = 1'b0, mSigned = 1'b0;
    int           mAge  = 0;
    logic [W-1:0] mHi = '0, mLo = '0, mX = '0, mY = '0, mPendHi = '0, mPendLo = '0;
    logic         expStall;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mBusy   <= 1'b0;
            mAge    <= 0;
            mHi     <= '0;
            mLo     <= '0;
            mX      <= '0;
            mY      <= '0;
            mSigned <= 1'b0;
        end else if (mBusy) begin
            if (exFlush) begin
                mBusy <= 1'b0;
            end else if (mAge == WB_AGE) begin
                mHi   <= mPendHi;
                mLo   <= mPendLo;
                mBusy <= 1'b0;
            end else begin
                mAge <= mAge + 1;
            end
        end else if (exValid && !exFlush) begin
            if (exDiv || exDivu) begin
                mBusy   <= 1'b1;
                mAge    <= 0;
                mX      <= exRs;
                mY      <= exRt;
                mSigned <= exDiv;
                {mPendHi, mPendLo} <= refDivide(exDiv, exRs, exRt);
            end else begin
                if (exMthi) mHi <= exRs;
                if (exMtlo) mLo <= exRs;
            end
        end
    end

    always_comb begin
        expStall = resetn & ((!mBusy & exValid & !exFlush & (exDiv | exDivu)) |
                             (mBusy & (mAge != WB_AGE)));
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEnable) begin
            checkOutput("ex_stall", 32'(exStall), 32'(expStall));
            checkOutput("div_start", 32'(divStart), 32'(mBusy));
            checkOutput("div_signed", 32'(divSigned), 32'(mSigned));
            checkOutput("div_x", divX, mX);
            checkOutput("div_y", divY, mY);
            checkOutput("hi", hi, mHi);
            checkOutput("lo", lo, mLo);
        end
    end

    task automatic applyStimulus(input logic v, input logic d, input logic du, input logic mh,
                                 input logic ml, input logic f, input logic [W-1:0] rs,
                                 input logic [W-1:0] rt);
        exValid = v;
        exDiv   = d;
        exDivu  = du;
        exMthi  = mh;
        exMtlo  = ml;
        exFlush = f;
        exRs    = rs;
        exRt    = rt;
    endtask

    task automatic idleEx();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Holds a divide in EX until it leaves; flushAt>0 flushes on that stall cycle, <0 on the complete cycle
    task automatic runDiv(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input int flushAt, output int stallN, output logic start1,
                          output logic start2, output logic sigSeen);
        int n;
        bit done;
        applyStimulus(1'b1, sgn, !sgn, 1'b0, 1'b0, 1'b0, rs, rt);
        stallN  = 0;
        n       = 0;
        done    = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        sigSeen = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (n == 0) start1 = divStart;
            if (n == 1) start2 = divStart;
            if (n >= 1) sigSeen = sigSeen | divSigned;
            if (exStall) begin
                stallN++;
                if (flushAt > 0 && stallN == flushAt) begin
                    #2 exFlush = 1'b1;
                    done = 1'b1;
                end
            end else begin
                done = 1'b1;
                if (flushAt < 0) begin
                    #2 exFlush = 1'b1;
                end
            end
            n++;
        end
        if (!done) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL div_timeout: stall still high after %0d cycles, required release", n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   stallN;
        logic s1, s2, sig;

        cmpEnable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_start", 32'(divStart), 32'h0);
        checkOutput("reset_stall", 32'(exStall), 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] signed divide -7 / 2");
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0, stallN, s1, s2, sig);
        checkOutput("t1_stall_cycles", 32'(stallN), 32'd34);
        checkOutput("t1_lo", lo, 32'hFFFF_FFFD);
        checkOutput("t1_hi", hi, 32'hFFFF_FFFF);
        checkOutput("t1_start_fell", 32'(divStart), 32'h0);
        checkOutput("t1_start_pre", 32'(s1), 32'h0);
        checkOutput("t1_start_post", 32'(s2), 32'h1);
        idleEx();
        @(posedge clk);
        #1;

        $display("[TB] unsigned divide 0xFFFFFFFF / 2");
        runDiv(1'b0, 32'hFFFF_FFFF, 32'd2, 0, stallN, s1, s2, sig);
        checkOutput("t2_lo", lo, 32'h7FFF_FFFF);
        checkOutput("t2_hi", hi, 32'h0000_0001);
        checkOutput("t2_signed_low", 32'(sig), 32'h0);
        idleEx();
        @(posedge clk);
        #1;

        $display("[TB] back-to-back 100/7 then 9/-4");
        runDiv(1'b1, 32'd100, 32'd7, 0, stallN, s1, s2, sig);
        checkOutput("t3a_lo", lo, 32'd14);
        checkOutput("t3a_hi", hi, 32'd2);
        runDiv(1'b1, 32'd9, 32'hFFFF_FFFC, 0, stallN, s1, s2, sig);
        checkOutput("t3_gap_low", 32'(s1), 32'h0);
        checkOutput("t3_gap_restart", 32'(s2), 32'h1);
        checkOutput("t3b_stall_cycles", 32'(stallN), 32'd34);
        checkOutput("t3b_lo", lo, 32'hFFFF_FFFE);
        checkOutput("t3b_hi", hi, 32'd1);
        idleEx();
        @(posedge clk);
        #1;

        $display("[TB] MTHI then MTLO");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, '0);
        @(negedge clk);
        checkOutput("t4_mthi_stall", 32'(exStall), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t4_hi", hi, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, '0);
        @(negedge clk);
        checkOutput("t4_mtlo_stall", 32'(exStall), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t4_lo", lo, 32'hCAFE_F00D);
        checkOutput("t4_hi_kept", hi, 32'h1234_5678);
        idleEx();
        @(posedge clk);
        #1;

        $display("[TB] flush on stall cycle 10, then a stray complete");
        runDiv(1'b1, 32'd1000, 32'd3, 10, stallN, s1, s2, sig);
        checkOutput("t5_stall_cycles", 32'(stallN), 32'd10);
        idleEx();
        checkOutput("t5_start_dropped", 32'(divStart), 32'h0);
        checkOutput("t5_stall_dropped", 32'(exStall), 32'h0);
        checkOutput("t5_hi", hi, 32'h1234_5678);
        checkOutput("t5_lo", lo, 32'hCAFE_F00D);
        repeat (40) @(posedge clk);
        #1;
        injS = 32'h0000_DEAD;
        injR = 32'h0000_BEEF;
        injC = 1'b1;
        @(posedge clk);
        #1;
        injC = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_stray_hi", hi, 32'h1234_5678);
        checkOutput("t5_stray_lo", lo, 32'hCAFE_F00D);

        $display("[TB] flush on the complete cycle");
        runDiv(1'b0, 32'd50, 32'd5, -1, stallN, s1, s2, sig);
        idleEx();
        checkOutput("t6_stall_cycles", 32'(stallN), 32'd34);
        checkOutput("t6_hi", hi, 32'h1234_5678);
        checkOutput("t6_lo", lo, 32'hCAFE_F00D);
        @(posedge clk);
        #1;

        $display("[TB] unsigned divide by zero");
        runDiv(1'b0, 32'd5, 32'd0, 0, stallN, s1, s2, sig);
        checkOutput("t7_lo", lo, 32'hFFFF_FFFF);
        checkOutput("t7_hi", hi, 32'd5);
        idleEx();
        @(posedge clk);
        #1;

        $display("[TB] asynchronous reset mid-divide");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd20, 32'd3);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t8_hi", hi, 32'h0);
        checkOutput("t8_lo", lo, 32'h0);
        checkOutput("t8_start", 32'(divStart), 32'h0);
        checkOutput("t8_stall", 32'(exStall), 32'h0);
        checkOutput("t8_div_x", divX, 32'h0);
        idleEx();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] divide after reset recovery");
        runDiv(1'b0, 32'd1000, 32'd10, 0, stallN, s1, s2, sig);
        checkOutput("t9_stall_cycles", 32'(stallN), 32'd34);
        checkOutput("t9_lo", lo, 32'd100);
        checkOutput("t9_hi", hi, 32'd0);
        idleEx();
        repeat (3) @(posedge clk);
        #1;

        cmpEnable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
